// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver, DATA_WIDTH data bits, optional parity, runtime Prescale (min 8).
// Latency: strobe 2 + F*P + P/2 + 2 clocks after the first clk edge that samples RX_IN low (F = 1 + DATA_WIDTH + PAR_EN).
// Backpressure: none; data_valid/par_err/frm_err are one-cycle strobes. Build macro UART_RX_MAJORITY_EN selects 2-of-3 bit sampling.
module uart_rx_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  par_err,
  output logic                  frm_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // bit counter only has to reach DATA_WIDTH-1
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(8);
  localparam logic [BW-1:0]         BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]         BIT_LAST = BW'(DATA_WIDTH - 1);

  // synchroniser
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  // frame control
  state_t                  r_state;
  logic [PRESCALE_W-1:0]   r_edge_cnt;
  logic [BW-1:0]           r_bit_cnt;
  logic [PRESCALE_W-1:0]   r_prescale;
  logic                    r_par_en;
  logic                    r_par_typ;
  logic                    r_par_bad;
  logic [DATA_WIDTH-1:0]   r_shift;

  // bit sampling
  logic                    r_samp_c;
`ifdef UART_RX_MAJORITY_EN
  logic                    r_samp_cm1;
  logic [PRESCALE_W-1:0]   w_cm1_idx;
`endif

  // derived timing points within a bit
  logic [PRESCALE_W-1:0]   w_p_eff;
  logic [PRESCALE_W-1:0]   w_center;
  logic [PRESCALE_W-1:0]   w_dec_idx;
  logic [PRESCALE_W-1:0]   w_last_idx;
  logic [PRESCALE_W-1:0]   w_cnt_next;
  logic                    w_dec;
  logic                    w_last;
  logic                    w_bit;
  logic                    w_par_calc;

  assign w_rx_s = r_sync2;

  // Prescale values below 8 leave too little room around the centre sample, so clamp them
  assign w_p_eff    = (Prescale < P_MIN) ? P_MIN : Prescale;

  assign w_center   = r_prescale >> 1;
  assign w_dec_idx  = w_center + P_ONE;
  assign w_last_idx = r_prescale - P_ONE;
  assign w_cnt_next = r_edge_cnt + P_ONE;
  assign w_dec      = (r_edge_cnt == w_dec_idx);
  assign w_last     = (r_edge_cnt == w_last_idx);

  // expected parity bit for the word now in the shift register
  assign w_par_calc = (^r_shift) ^ r_par_typ;

`ifdef UART_RX_MAJORITY_EN
  assign w_cm1_idx = w_center - P_ONE;
  // 2-of-3 vote: samples from c-1 and c are registered, the c+1 sample is the live line
  assign w_bit = (r_samp_cm1 & r_samp_c) | (r_samp_cm1 & w_rx_s) | (r_samp_c & w_rx_s);
`else
  // single centre sample, used one clock later at the decision edge
  assign w_bit = r_samp_c;
`endif

  // two-flop synchroniser on the pad input; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  // capture the line at the sample points leading up to the decision edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_c   <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      r_samp_cm1 <= 1'b1;
`endif
    end else if (r_state != S_IDLE) begin
      if (r_edge_cnt == w_center) begin
        r_samp_c <= w_rx_s;
      end
`ifdef UART_RX_MAJORITY_EN
      if (r_edge_cnt == w_cm1_idx) begin
        r_samp_cm1 <= w_rx_s;
      end
`endif
    end
  end

  // frame FSM with counters, shift register and registered result strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prescale <= P_MIN;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_bad  <= 1'b0;
      r_shift    <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      P_DATA     <= '0;
    end else begin
      // strobes default low so each one lasts exactly one cycle
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            // frame settings are frozen here so mid-frame changes only affect the next frame
            r_state    <= S_START;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= w_p_eff;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_bad  <= 1'b0;
          end
        end

        S_START: begin
          if (w_dec && w_bit) begin
            // line back high at the start-bit centre: treat as a glitch
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
          end else if (w_last) begin
            r_state    <= S_DATA;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_edge_cnt <= w_cnt_next;
          end
        end

        S_DATA: begin
          // LSB arrives first, so shift in from the top
          if (w_dec) begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          end
          if (w_last) begin
            r_edge_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
          end else begin
            r_edge_cnt <= w_cnt_next;
          end
        end

        S_PARITY: begin
          if (w_dec) begin
            r_par_bad <= (w_bit != w_par_calc);
          end
          if (w_last) begin
            r_state    <= S_STOP;
            r_edge_cnt <= '0;
          end else begin
            r_edge_cnt <= w_cnt_next;
          end
        end

        S_STOP: begin
          if (w_dec) begin
            // leave mid-stop-bit so a back-to-back start bit is caught at once
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            if (!w_bit) begin
              frm_err <= 1'b1;
            end else if (r_par_bad) begin
              par_err <= 1'b1;
            end else begin
              data_valid <= 1'b1;
              P_DATA     <= r_shift;
            end
          end else begin
            r_edge_cnt <= w_cnt_next;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen: directed and random frames against a waveform-decoding reference model.
// Expected strobes (kind, cycle, word) are predicted from the line waveform and compared in order.
// Build option UART_RX_MAJORITY_EN changes the model's bit sampling rule to match.
module tb_uart_rx_gen;

  localparam int DW = 8;
  localparam int PW = 6;

  localparam int K_VALID = 1;
  localparam int K_PAR   = 2;
  localparam int K_FRM   = 3;

  typedef struct {
    int cyc;
    int kind;
    int dat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = PW'(16);
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          data_valid;
  logic [DW-1:0] P_DATA;
  logic          par_err;
  logic          frm_err;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  last_word = 0;
  int  x;
  ev_t obs_q[$];
  ev_t exp_q[$];

  uart_rx_gen #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .data_valid(data_valid),
    .P_DATA    (P_DATA),
    .par_err   (par_err),
    .frm_err   (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe seen, one event per strobe per cycle
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst) begin
      e.cyc = cyc;
      e.dat = int'(P_DATA);
      if (data_valid) begin e.kind = K_VALID; obs_q.push_back(e); end
      if (par_err)    begin e.kind = K_PAR;   obs_q.push_back(e); end
      if (frm_err)    begin e.kind = K_FRM;   obs_q.push_back(e); end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // value of one bit slot as the receiver should judge it; slot 0 is the start bit.
  // Waveform index i is the value the first synchroniser flop samples i clocks after the first low.
  function automatic bit samp(input bit w[$], input int pe, input int slot);
    int base;
    base = 1 + slot * pe + pe / 2;
`ifdef UART_RX_MAJORITY_EN
    return (int'(w[base-1]) + int'(w[base]) + int'(w[base+1])) >= 2;
`else
    return w[base];
`endif
  endfunction

  task automatic send_frame(input int d, input int pr, input bit pen, input bit ptyp,
                            input bit bad_par, input bit bad_stop, input int flip_at,
                            input int cut_at, input int tail, output int xo);
    int  pe, c, f, dec;
    bit  wave[$];
    bit  pb, st;
    ev_t e;
    pe = (pr < 8) ? 8 : pr;
    c  = pe / 2;
    f  = 1 + DW + (pen ? 1 : 0);
    wave = {};
    repeat (pe) wave.push_back(1'b0);
    for (int b = 0; b < DW; b++) repeat (pe) wave.push_back(d[b]);
    if (pen) begin
      pb = (^d[DW-1:0]) ^ ptyp ^ bad_par;
      repeat (pe) wave.push_back(pb);
    end
    repeat (pe) wave.push_back(!bad_stop);
    if (flip_at >= 0) wave[flip_at] = !wave[flip_at];

    xo = 0;
    for (int i = 0; i < wave.size(); i++) begin
      if (i == cut_at) break;
      @(negedge clk);
      if (i == 0) begin
        xo = cyc; Prescale = PW'(pr); PAR_EN = pen; PAR_TYP = ptyp;
      end else if (i == pe) begin
        // scramble settings mid-frame; they must not affect this frame
        Prescale = PW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      end else if (i == f * pe) begin
        Prescale = PW'(pr); PAR_EN = pen; PAR_TYP = ptyp;
      end
      RX_IN = wave[i];
    end

    if (cut_at < 0) begin
      if (!samp(wave, pe, 0)) begin
        dec = 0;
        for (int b = 0; b < DW; b++) dec = dec | (int'(samp(wave, pe, 1 + b)) << b);
        st  = samp(wave, pe, f);
        e.cyc = xo + 1 + f * pe + c + 4;
        if (!st) e.kind = K_FRM;
        else if (pen && (samp(wave, pe, 1 + DW) != ((^dec[DW-1:0]) ^ ptyp))) e.kind = K_PAR;
        else begin e.kind = K_VALID; last_word = dec; end
        e.dat = last_word;
        exp_q.push_back(e);
      end
      repeat (tail) begin @(negedge clk); RX_IN = 1'b1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); RX_IN = 1'b1; end
  endtask

  initial begin
    int nf;
    ev_t o, e;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data_valid", data_valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_frm_err", frm_err, 0);
    check("rst_p_data", P_DATA, 0);
    rst = 1'b0;
    idle(5);

    // basic frame and its latency
    send_frame(8'hA5, 16, 0, 0, 0, 0, -1, -1, 30, x);
    if (obs_q.size() == 0) check("lat156_seen", 0, 1);
    else check("lat156", obs_q[$].cyc - (x + 1), 156);

    // parity: wrong then right parity bit on 0x03
    send_frame(8'h03, 16, 1, 0, 1, 0, -1, -1, 30, x);
    send_frame(8'h03, 16, 1, 0, 0, 0, -1, -1, 30, x);

    // framing error on 0x55
    send_frame(8'h55, 16, 0, 0, 0, 1, -1, -1, 30, x);

    // 4-clock start glitch, then a good frame
    repeat (4) begin @(negedge clk); RX_IN = 1'b0; end
    idle(16);
    send_frame(8'h96, 16, 0, 0, 0, 0, -1, -1, 30, x);

    // single-clock inversion at the centre of data bit 2 of 0x00
    send_frame(8'h00, 16, 0, 0, 0, 0, 1 + 3 * 16 + 8, -1, 30, x);

    // reset in the middle of data bit 4
    send_frame(8'hC3, 16, 0, 0, 0, 0, -1, 16 * 5 + 8, 0, x);
    @(negedge clk); rst = 1'b1; RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data_valid", data_valid, 0);
    check("midrst_par_err", par_err, 0);
    check("midrst_frm_err", frm_err, 0);
    check("midrst_p_data", P_DATA, 0);
    rst = 1'b0;
    last_word = 0;
    idle(20);
    send_frame(8'h3C, 16, 0, 0, 0, 0, -1, -1, 30, x);

    // line held low at P=8: frm_err every 9*8+4+3 clocks, never data_valid
    @(negedge clk); x = cyc; Prescale = PW'(8); PAR_EN = 1'b0; RX_IN = 1'b0;
    nf = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frm_err) nf++;
      if (nf == 3) break;
    end
    RX_IN = 1'b1;
    check("held_low_frm_cnt", nf, 3);
    for (int j = 0; j < 3; j++) begin
      e.cyc = x + 1 + 9 * 8 + 4 + 4 + j * (9 * 8 + 4 + 3);
      e.kind = K_FRM; e.dat = last_word;
      exp_q.push_back(e);
    end
    idle(40);

    // random frames, settings, errors and back-to-back spacing
    for (int n = 0; n < 40; n++) begin
      int pr, pe, d, tl;
      bit pen, ptyp, bp, bs;
      pr   = $urandom_range(0, 24);
      pe   = (pr < 8) ? 8 : pr;
      d    = $urandom_range(0, 255);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      bp   = pen && ($urandom_range(0, 4) == 0);
      bs   = ($urandom_range(0, 5) == 0);
      tl   = (!bs && ($urandom_range(0, 2) == 0)) ? 0 : pe + 8 + $urandom_range(0, 10);
      send_frame(d, pr, pen, ptyp, bp, bs, -1, -1, tl, x);
    end
    idle(300);

    // ordered comparison of all strobes
    check("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("ev%0d_kind", i), o.kind, e.kind);
      check($sformatf("ev%0d_cycle", i), o.cyc, e.cyc);
      check($sformatf("ev%0d_word", i), o.dat, e.dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
